// File: rtl/wall_collide.sv
// wall_collide: tests a square probe box against a tiled playfield.
// Ports: clk, reset_n (async low); req_valid/req_ready + probe_x/y/s in;
// resp_valid/resp_ready + hit, oob, hit_col, hit_row out.
module wall_collide #(
    parameter int TILE_SHIFT = 5,
    parameter int COLS       = 20,
    parameter int ROWS       = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [9:0] probe_x,
    input  logic [9:0] probe_y,
    input  logic [9:0] probe_s,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic       hit,
    output logic       oob,
    output logic [4:0] hit_col,
    output logic [4:0] hit_row
);

    localparam logic [10:0] X_MAX    = 11'(COLS << TILE_SHIFT);
    localparam logic [10:0] Y_MAX    = 11'(ROWS << TILE_SHIFT);
    localparam logic [4:0]  LAST_COL = 5'(COLS - 1);
    localparam logic [4:0]  LAST_ROW = 5'(ROWS - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SCAN, DONE} state_t;

    state_t      state, state_nxt;
    logic [9:0]  px, py, ps;
    logic [4:0]  c0, c1, r1;
    logic [4:0]  col, row;
    logic [10:0] x_end, y_end, x_last, y_last;
    logic        zero_s, off_field, wall, last_tile;
    logic        unused_bits;

    // 11-bit sums so a box hanging off the right/bottom never wraps
    assign x_end  = {1'b0, px} + {1'b0, ps};
    assign y_end  = {1'b0, py} + {1'b0, ps};
    assign x_last = x_end - 11'd1;
    assign y_last = y_end - 11'd1;

    assign zero_s    = (ps == 10'd0);
    assign off_field = (x_end > X_MAX) || (y_end > Y_MAX);

    // border tiles plus a pillar on every even/even tile
    assign wall = (col == 5'd0) || (col == LAST_COL) ||
                  (row == 5'd0) || (row == LAST_ROW) ||
                  (!col[0] && !row[0]);
    assign last_tile = (col == c1) && (row == r1);

    // only the tile-index slice of the end coordinates is meaningful
    assign unused_bits = ^{x_last, y_last};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = SETUP;
            end
            SETUP: begin
                if (zero_s || off_field) state_nxt = DONE;
                else                     state_nxt = SCAN;
            end
            SCAN: begin
                if (wall || last_tile) state_nxt = DONE;
            end
            DONE: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            px      <= '0;
            py      <= '0;
            ps      <= '0;
            c0      <= '0;
            c1      <= '0;
            r1      <= '0;
            col     <= '0;
            row     <= '0;
            hit     <= 1'b0;
            oob     <= 1'b0;
            hit_col <= '0;
            hit_row <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        px <= probe_x;
                        py <= probe_y;
                        ps <= probe_s;
                    end
                end
                SETUP: begin
                    if (zero_s || off_field) begin
                        hit     <= !zero_s;
                        oob     <= !zero_s;
                        hit_col <= '0;
                        hit_row <= '0;
                    end else begin
                        c0  <= px[TILE_SHIFT +: 5];
                        c1  <= x_last[TILE_SHIFT +: 5];
                        r1  <= y_last[TILE_SHIFT +: 5];
                        col <= px[TILE_SHIFT +: 5];
                        row <= py[TILE_SHIFT +: 5];
                    end
                end
                SCAN: begin
                    if (wall) begin
                        hit     <= 1'b1;
                        oob     <= 1'b0;
                        hit_col <= col;
                        hit_row <= row;
                    end else if (last_tile) begin
                        hit     <= 1'b0;
                        oob     <= 1'b0;
                        hit_col <= '0;
                        hit_row <= '0;
                    end else if (col == c1) begin
                        col <= c0;
                        row <= row + 5'd1;
                    end else begin
                        col <= col + 5'd1;
                    end
                end
                DONE: ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wall_collide.sv
// tb_wall_collide: directed probes against wall_collide with
// hand-computed tile results and response latencies.
module tb_wall_collide;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [9:0] probe_x = '0;
    logic [9:0] probe_y = '0;
    logic [9:0] probe_s = '0;
    logic       resp_valid;
    logic       resp_ready = 1'b0;
    logic       hit;
    logic       oob;
    logic [4:0] hit_col;
    logic [4:0] hit_row;

    int vectors = 0;
    int errors  = 0;

    wall_collide dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .probe_x    (probe_x),
        .probe_y    (probe_y),
        .probe_s    (probe_s),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .hit        (hit),
        .oob        (oob),
        .hit_col    (hit_col),
        .hit_row    (hit_row)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // handshake completes on edge k; returns just after it
    task automatic issue(input string tag, input int x, input int y,
                         input int s);
        @(negedge clk);
        probe_x   = 10'(x);
        probe_y   = 10'(y);
        probe_s   = 10'(s);
        req_valid = 1'b1;
        check({tag, ".req_ready"}, int'(req_ready), 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // number of edges after k until resp_valid; 99 if it never comes
    task automatic await(output int lat);
        lat = 99;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (resp_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic take(input string tag);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check({tag, ".idle_valid"}, int'(resp_valid), 0);
        check({tag, ".idle_ready"}, int'(req_ready), 1);
    endtask

    task automatic run(input string tag, input int x, input int y,
                       input int s, input int elat, input int ehit,
                       input int eoob, input int ecol, input int erow);
        int lat;
        issue(tag, x, y, s);
        await(lat);
        check({tag, ".lat"}, lat, elat);
        check({tag, ".hit"}, int'(hit), ehit);
        check({tag, ".oob"}, int'(oob), eoob);
        check({tag, ".col"}, int'(hit_col), ecol);
        check({tag, ".row"}, int'(hit_row), erow);
        take(tag);
    endtask

    initial begin
        int lat;

        repeat (3) @(posedge clk);
        #1;
        check("rst.req_ready", int'(req_ready), 1);
        check("rst.resp_valid", int'(resp_valid), 0);
        check("rst.hit", int'(hit), 0);
        check("rst.oob", int'(oob), 0);
        check("rst.col", int'(hit_col), 0);
        check("rst.row", int'(hit_row), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // tag        x    y    s   lat hit oob col row
        run("single",   32,  32,  32, 2, 0, 0,  0,  0);
        run("quad",     40,  40,  32, 5, 1, 0,  2,  2);
        run("pair",     33,  96,  32, 3, 0, 0,  0,  0);
        run("odd",      96,  96,  32, 2, 0, 0,  0,  0);
        run("oob_x",   620, 100,  32, 1, 1, 1,  0,  0);
        run("wrap",   1000,   0, 100, 1, 1, 1,  0,  0);
        run("zero",    100, 100,   0, 1, 0, 0,  0,  0);
        run("corner",  608, 448,  32, 2, 1, 0, 19, 14);
        run("oob_y",     0, 449,  32, 1, 1, 1,  0,  0);

        // stall the consumer; late request pulses must not register
        issue("hold", 40, 40, 32);
        await(lat);
        check("hold.lat", lat, 5);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            req_valid = i[0];
            probe_x   = 10'd600;
            probe_y   = 10'd0;
            probe_s   = 10'd100;
            @(posedge clk);
            #1;
            check("hold.valid", int'(resp_valid), 1);
            check("hold.ready", int'(req_ready), 0);
            check("hold.hit", int'(hit), 1);
            check("hold.oob", int'(oob), 0);
            check("hold.col", int'(hit_col), 2);
            check("hold.row", int'(hit_row), 2);
        end
        req_valid = 1'b0;
        take("hold");

        // abort a scan with reset; outputs clear without a clock
        issue("abort", 40, 40, 32);
        @(posedge clk);
        @(posedge clk);
        #2;
        check("abort.in_scan", int'(resp_valid), 0);
        reset_n = 1'b0;
        #1;
        check("abort.req_ready", int'(req_ready), 1);
        check("abort.resp_valid", int'(resp_valid), 0);
        check("abort.hit", int'(hit), 0);
        check("abort.col", int'(hit_col), 0);
        check("abort.row", int'(hit_row), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        run("after", 64, 64, 32, 2, 1, 0, 2, 2);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
